fifo_sync: RTL and testbench
============================

# fifo_sync

Single-clock, parametrised successor to the dual-clock 4k FIFO wrapper. It provides depth/width parameters, a full-depth fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous clear. It sits between rate-matched datapath stages inside one clock domain, such as the RX decimator output into the packetiser and the TX packet parser into the interpolator, where a dual-clock FIFO is unnecessary.

## Interface
- WIDTH, 16, data word width.
- DEPTH, 4096, number of words; must equal 2**ADDR_BITS.
- ADDR_BITS, 12, RAM address width.
- clock  in  1  sole clock, rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear: empties FIFO and clears error flags; has priority over wrreq/rdreq.
- data  in  WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request.
- af_thresh  in  ADDR_BITS+1  almost-full threshold, quasi-static.
- ae_thresh  in  ADDR_BITS+1  almost-empty threshold, quasi-static.
- q  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  no readable word.
- usedw  out  ADDR_BITS+1  words held, 0..DEPTH.
- almost_full  out  1  usedw >= af_thresh.
- almost_empty  out  1  usedw <= ae_thresh.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Write pointer and read pointer are each ADDR_BITS+1 bits. RAM is addressed by the low ADDR_BITS, and wrap-around is natural modulo 2**(ADDR_BITS+1).
- usedw is the registered count, updated by +1 on write only, −1 on read only, and unchanged on both or neither.
- A write is accepted iff wrreq && !full, judged on the flag values before the clock edge. When full, a simultaneous read does not admit the write in the same cycle.
- A read is accepted iff rdreq && !empty. When empty, a simultaneous write does not make the read succeed.
- A rejected write sets overflow and does not modify the RAM, pointers or count. A rejected read sets underflow, and q holds its value.
- full, empty, almost_full and almost_empty are derived from registered state plus thresholds only, with no combinational path from wrreq or rdreq.
- sclr: pointers, count, overflow and underflow are set to 0; q and RAM contents are unchanged.
- Reset (aclr_n low) has the same effect as sclr and also sets q to 0. Outputs at reset: q=0, full=0, empty=1, usedw=0, overflow=0, underflow=0. almost_full and almost_empty follow the thresholds with usedw=0.
- Assertion of aclr_n mid-operation takes effect immediately and discards all stored data.

## Timing
- Default (show-ahead off): q is updated on the edge after an accepted read (read latency 1 cycle). q holds between reads.
- Write to an empty FIFO: empty deasserts and usedw=1 on the next edge. The word can be read in that cycle.
- Flags and usedw reflect all operations accepted at edge N starting at N+1.
- Continuous simultaneous read and write at steady state sustains one word per clock with usedw constant.

## Configuration
- FIFO_SYNC_SHOWAHEAD_EN defined:
  - q presents the head word whenever empty=0, and rdreq acknowledges (pops) it.
  - An output register with a valid bit is added. empty equals !valid.
  - A write to an empty FIFO makes empty deassert 2 edges later (RAM read, then output register).
  - usedw and full count the word held in the output register.
  - After a pop, the next word appears on the following edge, with no gap at full throughput.
- Not defined: the plain 1-cycle-latency read described above, with no output-stage register.

## Structure
- Shared package fifo_pkg holds the clog2 helper function and the parameter-legality check (DEPTH == 2**ADDR_BITS), which reports an elaboration error on mismatch.
- One sub-module, fifo_sync_ram: a simple dual-port RAM with WIDTH×DEPTH storage, a synchronous write port and a registered read port, inferable to block RAM.
- Pointer, count, flag and show-ahead logic live in fifo_sync itself.

## Test plan
- Reset, then write 0x0001..0x1000 (4096 words) → full=1 and usedw=4096 after the last edge. A further wrreq → overflow=1, and usedw stays 4096.
- Read all 4096 words → q sequence 0x0001..0x1000 in order, then empty=1. A further rdreq → underflow=1, and q holds 0x1000.
- af_thresh=100, ae_thresh=4. Write 100 words → almost_full rises on the edge after the 100th write. Read 96 words → almost_empty rises at usedw=4.
- With usedw=10, assert wrreq and rdreq together for 50 cycles → usedw stays 10 and the output is in order. Repeat at full=1 → read accepted, write rejected, overflow=1, usedw=4095.
- Pointer wrap: cycle 3×DEPTH words through at half-full occupancy → no data corruption and the usedw arithmetic stays correct.
- With usedw=37, pulse sclr while wrreq=1 → usedw=0, empty=1, overflow and underflow cleared, and the write is dropped. Repeat with aclr_n low for part of a cycle → immediate reset state and q=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: clog2 and the depth/address-width legality check.
package fifo_pkg;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned v;
    int unsigned     bits;
    v    = (value > 64'd0) ? value - 64'd1 : 64'd0;
    bits = 0;
    while (v > 64'd0) begin
      v    = v >> 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  // DEPTH must be exactly 2**ADDR_BITS so pointer wrap matches RAM wrap.
  function automatic bit depth_ok(input int unsigned depth, input int unsigned addr_bits);
    if (addr_bits >= 32) return 1'b0;
    return (64'(depth) == (64'd1 << addr_bits)) && (clog2(64'(depth)) == addr_bits);
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Data/handshake/status bundle for fifo_sync; master is the user side, slave the FIFO.
interface fifo_sync_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 12
);
  logic                 sclr;
  logic [WIDTH-1:0]     data;
  logic                 wrreq;
  logic                 rdreq;
  logic [ADDR_BITS:0]   af_thresh;
  logic [ADDR_BITS:0]   ae_thresh;
  logic [WIDTH-1:0]     q;
  logic                 full;
  logic                 empty;
  logic [ADDR_BITS:0]   usedw;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output sclr, data, wrreq, rdreq, af_thresh, ae_thresh,
    input  q, full, empty, usedw, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  sclr, data, wrreq, rdreq, af_thresh, ae_thresh,
    output q, full, empty, usedw, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, registered read, block-RAM inferable.
module fifo_sync_ram #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with fill count, programmable thresholds, sticky error flags and sclr.
// Optional show-ahead output stage: define FIFO_SYNC_SHOWAHEAD_EN.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic        clock,
  input  logic        aclr_n,
  fifo_sync_if.slave  bus
);
  localparam int unsigned PW = ADDR_BITS + 1;

  if (!depth_ok(DEPTH, ADDR_BITS)) begin : g_bad_depth
    $error("fifo_sync: DEPTH (%0d) must equal 2**ADDR_BITS (ADDR_BITS=%0d)", DEPTH, ADDR_BITS);
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, count;
  logic             overflow_r, underflow_r;
  logic             is_full, is_empty;
  logic             wr_ok, pop, fetch;
  logic [WIDTH-1:0] ram_rdata;

  assign is_full = (count == PW'(DEPTH));
  assign wr_ok   = bus.wrreq && !is_full && !bus.sclr;

  fifo_sync_ram #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
    .clock (clock),
    .aclr_n(aclr_n),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata (bus.data),
    .re    (fetch),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (ram_rdata)
  );

`ifdef FIFO_SYNC_SHOWAHEAD_EN
  logic             s1_valid, out_valid, s1_move;
  logic [WIDTH-1:0] q_r;

  // Pop the output register; refill it from the RAM stage; fetch when the RAM stage frees up.
  assign is_empty = !out_valid;
  assign pop      = bus.rdreq && out_valid && !bus.sclr;
  assign s1_move  = s1_valid && (!out_valid || pop) && !bus.sclr;
  assign fetch    = (wr_ptr != rd_ptr) && (!s1_valid || s1_move) && !bus.sclr;

  // Two-stage head pipeline: RAM read register, then output register.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      q_r       <= '0;
    end else if (bus.sclr) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (fetch)        s1_valid <= 1'b1;
      else if (s1_move) s1_valid <= 1'b0;
      if (s1_move) begin
        out_valid <= 1'b1;
        q_r       <= ram_rdata;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.q = q_r;
`else
  // Plain mode: the RAM read register is the output, one cycle after an accepted read.
  assign is_empty = (count == '0);
  assign pop      = bus.rdreq && !is_empty && !bus.sclr;
  assign fetch    = pop;
  assign bus.q    = ram_rdata;
`endif

  // Pointers, fill count and sticky error flags.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.sclr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (fetch) rd_ptr <= rd_ptr + PW'(1);
      if (wr_ok && !pop)      count <= count + PW'(1);
      else if (pop && !wr_ok) count <= count - PW'(1);
      if (bus.wrreq && is_full)  overflow_r  <= 1'b1;
      if (bus.rdreq && is_empty) underflow_r <= 1'b1;
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.usedw        = count;
  assign bus.almost_full  = (count >= bus.af_thresh);
  assign bus.almost_empty = (count <= bus.ae_thresh);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_sync.sv
// Randomised self-checking bench for fifo_sync (default plain-read build) against a queue model.
module tb_fifo_sync;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned DEPTH     = 4096;

  logic clk;
  logic aclr_n;

  fifo_sync_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clock (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, last read word, sticky flags.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] q_exp;
  bit               ovf_exp;
  bit               unf_exp;
  int               af_t;
  int               ae_t;

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".q"},            32'(bus.q),            32'(q_exp));
    check({tag, ".usedw"},        32'(bus.usedw),        32'(n));
    check({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
    check({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= af_t));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= ae_t));
    check({tag, ".overflow"},     32'(bus.overflow),     32'(ovf_exp));
    check({tag, ".underflow"},    32'(bus.underflow),    32'(unf_exp));
  endtask

  task automatic set_thresh(input int af, input int ae);
    af_t          = af;
    ae_t          = ae;
    bus.af_thresh = 13'(af);
    bus.ae_thresh = 13'(ae);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input string tag, input bit wr, input bit rd,
                      input logic [WIDTH-1:0] d, input bit clr);
    bit wok;
    bit rok;
    bus.wrreq = wr;
    bus.rdreq = rd;
    bus.data  = d;
    bus.sclr  = clr;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      ovf_exp = 1'b0;
      unf_exp = 1'b0;
    end else begin
      wok = wr && (mq.size() < DEPTH);
      rok = rd && (mq.size() > 0);
      if (wr && !wok) ovf_exp = 1'b1;
      if (rd && !rok) unf_exp = 1'b1;
      if (rok) q_exp = mq.pop_front();
      if (wok) mq.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    q_exp   = '0;
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    aclr_n    = 1'b0;
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;
    set_thresh(100, 4);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    aclr_n = 1'b1;

    // Fill with 0x0001..0x1000, then one write too many.
    for (int i = 1; i <= 4096; i++) step("fill", 1'b1, 1'b0, 16'(i), 1'b0);
    step("overflow", 1'b1, 1'b0, 16'hdead, 1'b0);

    // Drain in order, then one read too many; q must hold 0x1000.
    for (int i = 0; i < 4096; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);
    step("underflow", 1'b0, 1'b1, '0, 1'b0);
    check("q_hold", 32'(bus.q), 32'h1000);

    // Threshold crossings: up to 100 words, then down to 4.
    step("sclr0", 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 100; i++) step("af_up", 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 96; i++)  step("ae_down", 1'b0, 1'b1, '0, 1'b0);

    // usedw=10, simultaneous read+write for 50 cycles.
    for (int i = 0; i < 6; i++)  step("to10", 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 50; i++) step("rw10", 1'b1, 1'b1, 16'($urandom), 1'b0);

    // Fill to full, then simultaneous read+write.
    while (mq.size() < DEPTH) step("tofull", 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step("rwfull", 1'b1, 1'b1, 16'($urandom), 1'b0);

    // Pointer wrap at around half occupancy with random traffic and thresholds.
    step("sclr1", 1'b0, 1'b0, '0, 1'b1);
    set_thresh(int'($urandom_range(0, DEPTH)), int'($urandom_range(0, DEPTH)));
    for (int i = 0; i < 2048; i++) step("half", 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 16384; i++)
      step("wrap", ($urandom % 4) != 0, ($urandom % 4) != 0, 16'($urandom), 1'b0);

    // sclr with a simultaneous write at usedw=37.
    set_thresh(100, 4);
    step("sclr2", 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 37; i++) step("to37", 1'b1, 1'b0, 16'($urandom), 1'b0);
    step("ovf_set", 1'b0, 1'b0, '0, 1'b0);
    step("sclr_wr", 1'b1, 1'b0, 16'h1234, 1'b1);
    step("after_sclr", 1'b0, 1'b1, '0, 1'b0);

    // Asynchronous reset pulse mid-cycle after some traffic.
    for (int i = 0; i < 37; i++) step("pre_rst", 1'b1, 1'b0, 16'($urandom) | 16'h1, 1'b0);
    for (int i = 0; i < 3; i++)  step("pre_rst_rd", 1'b0, 1'b1, '0, 1'b0);
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    aclr_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    aclr_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst", 1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) step("post_rst_rd", 1'b0, 1'b1, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
